// File: rtl/master_port_stage.sv
// Output stage for one crossbar master port. It locks onto the granted slave for a
// whole packet and buffers that slave's beats in a 2-entry FIFO that drives the port.
module master_port_stage #(
  parameter int T_DATA_WIDTH = 8,
  parameter int S_DATA_COUNT = 2,
  parameter int M_DATA_COUNT = 3,
  parameter int T_ID___WIDTH = $clog2(S_DATA_COUNT),
  parameter int T_DEST_WIDTH = $clog2(M_DATA_COUNT),
  parameter int MASTER_IDX   = 0
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [T_DATA_WIDTH-1:0] s_data_i  [S_DATA_COUNT],
  input  logic [T_DEST_WIDTH-1:0] s_dest_i  [S_DATA_COUNT],
  input  logic [S_DATA_COUNT-1:0] s_last_i,
  input  logic [S_DATA_COUNT-1:0] s_valid_i,
  output logic [S_DATA_COUNT-1:0] s_ready_o,
  input  logic [T_ID___WIDTH-1:0] grant_i,
  output logic [T_DATA_WIDTH-1:0] m_data_o,
  output logic                    m_last_o,
  output logic [T_ID___WIDTH-1:0] m_id_o,
  output logic                    m_valid_o,
  input  logic                    m_ready_i,
  output logic                    busy_o
);

  localparam logic ST_IDLE = 1'b0;
  localparam logic ST_BUSY = 1'b1;
  localparam logic [T_DEST_WIDTH-1:0] MY_DEST = T_DEST_WIDTH'(MASTER_IDX);

  logic                    state_q, state_d;
  logic [T_ID___WIDTH-1:0] lock_q, lock_d;
  logic [1:0]              count_q, count_d;
  logic [T_DATA_WIDTH-1:0] data_q [2];
  logic [T_DATA_WIDTH-1:0] data_d [2];
  logic [1:0]              last_q, last_d;
  logic [T_ID___WIDTH-1:0] id_q [2];
  logic [T_ID___WIDTH-1:0] id_d [2];

  logic req;
  logic accept;
  logic pop;

  assign req = s_valid_i[grant_i] && (s_dest_i[grant_i] == MY_DEST);

  // Ready depends only on registered state, so a pop at count 2 frees space one cycle later.
  always_comb begin
    // NOTE: every signal driven here gets a default first so no latch is inferred.
    s_ready_o = '0;
    if (state_q == ST_BUSY && count_q != 2'd2) s_ready_o[lock_q] = 1'b1;
  end

  assign accept = s_valid_i[lock_q] & s_ready_o[lock_q];
  assign pop    = m_valid_o & m_ready_i;

  always_comb begin
    state_d = state_q;
    lock_d  = lock_q;
    case (state_q)
      ST_IDLE: begin
        if (req) begin
          state_d = ST_BUSY;
          lock_d  = grant_i;
        end
      end
      default: begin
        if (accept && s_last_i[lock_q]) state_d = ST_IDLE;
      end
    endcase
  end

  // Slot 0 is always the head; a pop shifts slot 1 down before any push lands.
  always_comb begin
    data_d  = data_q;
    last_d  = last_q;
    id_d    = id_q;
    count_d = count_q + {1'b0, accept} - {1'b0, pop};
    if (pop) begin
      data_d[0] = data_q[1];
      last_d[0] = last_q[1];
      id_d[0]   = id_q[1];
    end
    if (accept) begin
      if (count_q == 2'd0 || pop) begin
        data_d[0] = s_data_i[lock_q];
        last_d[0] = s_last_i[lock_q];
        id_d[0]   = lock_q;
      end else begin
        data_d[1] = s_data_i[lock_q];
        last_d[1] = s_last_i[lock_q];
        id_d[1]   = lock_q;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      // NOTE: buffer storage is reset too, because the head entry drives the port directly.
      state_q <= ST_IDLE;
      lock_q  <= '0;
      count_q <= 2'd0;
      data_q  <= '{default: '0};
      last_q  <= '0;
      id_q    <= '{default: '0};
    end else begin
      // NOTE: non-blocking assignments so all registers update from the same pre-edge values.
      state_q <= state_d;
      lock_q  <= lock_d;
      count_q <= count_d;
      data_q  <= data_d;
      last_q  <= last_d;
      id_q    <= id_d;
    end
  end

  assign m_data_o  = data_q[0];
  assign m_last_o  = last_q[0];
  assign m_id_o    = id_q[0];
  assign m_valid_o = (count_q != 2'd0);
  assign busy_o    = (state_q == ST_BUSY);

endmodule

// File: tb/tb_master_port_stage.sv
// Self-checking bench for master_port_stage: a vector table, directed corner-case
// sequences and randomized traffic compared against a queue-based packet model.
module tb_master_port_stage;

  localparam int W   = 8;
  localparam int S   = 2;
  localparam int M   = 3;
  localparam int IW  = 1;
  localparam int DW  = 2;
  localparam int IDX = 0;

  logic          clk = 1'b0;
  logic          rst;
  logic [W-1:0]  s_data [S];
  logic [DW-1:0] s_dest [S];
  logic [S-1:0]  s_last, s_valid, s_ready;
  logic [IW-1:0] grant;
  logic [W-1:0]  m_data;
  logic          m_last;
  logic [IW-1:0] m_id;
  logic          m_valid, m_ready, busy;

  always #5 clk = ~clk;

  master_port_stage #(
    .T_DATA_WIDTH(W), .S_DATA_COUNT(S), .M_DATA_COUNT(M),
    .T_ID___WIDTH(IW), .T_DEST_WIDTH(DW), .MASTER_IDX(IDX)
  ) dut (
    .clk_i(clk), .rst_i(rst),
    .s_data_i(s_data), .s_dest_i(s_dest), .s_last_i(s_last), .s_valid_i(s_valid),
    .s_ready_o(s_ready), .grant_i(grant),
    .m_data_o(m_data), .m_last_o(m_last), .m_id_o(m_id), .m_valid_o(m_valid),
    .m_ready_i(m_ready), .busy_o(busy)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: packet lock flag plus a plain queue of buffered beats.
  typedef struct {
    logic [W-1:0]  data;
    logic          last;
    logic [IW-1:0] id;
  } beat_t;

  beat_t mq[$];
  bit    m_locked = 1'b0;
  int    m_lock   = 0;

  function automatic logic [S-1:0] exp_ready();
    logic [S-1:0] r = '0;
    if (m_locked && mq.size() < 2) r[m_lock] = 1'b1;
    return r;
  endfunction

  // Slave sources: each slave replays its current packet, advancing on handshake.
  logic [W-1:0]  src_pkt [S][8];
  logic [DW-1:0] src_dst [S];
  int            src_len [S];
  int            src_pos [S];
  int            gap_pct = 0;
  logic [W-1:0]  rx[$];

  task automatic src_drive();
    for (int s = 0; s < S; s++) begin
      s_dest[s] = src_dst[s];
      if (src_pos[s] < src_len[s] && $urandom_range(99) >= gap_pct) begin
        s_valid[s] = 1'b1;
        s_data[s]  = src_pkt[s][src_pos[s]];
        s_last[s]  = (src_pos[s] == src_len[s] - 1);
      end else begin
        s_valid[s] = 1'b0;
        s_data[s]  = '0;
        s_last[s]  = 1'b0;
      end
    end
  endtask

  task automatic step(input bit chk);
    bit do_pop, do_acc;
    if (chk) begin
      check("s_ready", s_ready, exp_ready());
      check("busy", busy, m_locked);
      check("m_valid", m_valid, mq.size() != 0);
      if (mq.size() != 0) begin
        check("m_data", m_data, mq[0].data);
        check("m_last", m_last, mq[0].last);
        check("m_id", m_id, mq[0].id);
      end
    end
    if (m_valid && m_ready && !rst) rx.push_back(m_data);
    for (int s = 0; s < S; s++) if (s_valid[s] && s_ready[s]) src_pos[s]++;
    if (rst) begin
      mq.delete();
      m_locked = 1'b0;
      m_lock   = 0;
    end else begin
      do_pop = (mq.size() != 0) && m_ready;
      do_acc = m_locked && (mq.size() < 2) && s_valid[m_lock];
      if (do_pop) void'(mq.pop_front());
      if (do_acc) mq.push_back('{s_data[m_lock], s_last[m_lock], IW'(m_lock)});
      if (!m_locked) begin
        if (s_valid[grant] && s_dest[grant] == DW'(IDX)) begin
          m_locked = 1'b1;
          m_lock   = int'(grant);
        end
      end else if (do_acc && s_last[m_lock]) begin
        m_locked = 1'b0;
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic cyc();
    src_drive();
    step(1'b1);
  endtask

  task automatic clear_src();
    for (int s = 0; s < S; s++) begin
      src_len[s] = 0;
      src_pos[s] = 0;
      src_dst[s] = DW'(IDX);
    end
  endtask

  task automatic do_reset();
    rst     = 1'b1;
    s_valid = '0;
    m_ready = 1'b0;
    step(1'b1);
    step(1'b1);
    rst = 1'b0;
    clear_src();
    rx.delete();
  endtask

  task automatic set_pkt(input int s, input logic [W-1:0] base, input int len, input logic [DW-1:0] dst);
    for (int i = 0; i < len; i++) src_pkt[s][i] = base + W'(i);
    src_len[s] = len;
    src_pos[s] = 0;
    src_dst[s] = dst;
  endtask

  task automatic check_rx(input string name, input logic [W-1:0] exp[$]);
    check({name, "_count"}, rx.size(), exp.size());
    for (int i = 0; i < exp.size(); i++)
      check(name, (i < rx.size()) ? 32'(rx[i]) : 32'hDEAD_BEEF, exp[i]);
  endtask

  typedef struct {
    logic          rst;
    logic [S-1:0]  valid;
    logic [S-1:0]  last;
    logic [IW-1:0] grant;
    logic          mready;
    logic [W-1:0]  d1;
    logic [S-1:0]  e_ready;
    logic          e_valid;
    logic [W-1:0]  e_data;
    logic          e_last;
    logic [IW-1:0] e_id;
    logic          e_busy;
    logic          cd;
  } vec_t;

  function automatic vec_t mk(logic r, logic [S-1:0] v, logic [S-1:0] l, logic [IW-1:0] g,
                              logic mr, logic [W-1:0] d1, logic [S-1:0] er, logic ev,
                              logic [W-1:0] ed, logic el, logic [IW-1:0] ei, logic eb, logic cd);
    vec_t t;
    t.rst = r; t.valid = v; t.last = l; t.grant = g; t.mready = mr; t.d1 = d1;
    t.e_ready = er; t.e_valid = ev; t.e_data = ed; t.e_last = el; t.e_id = ei;
    t.e_busy = eb; t.cd = cd;
    return t;
  endfunction

  vec_t tbl[8];
  int   viol;

  initial begin
    rst = 1'b1; s_valid = '0; s_last = '0; grant = '0; m_ready = 1'b0;
    for (int s = 0; s < S; s++) begin s_data[s] = '0; s_dest[s] = '0; end
    clear_src();
    repeat (2) @(posedge clk);
    @(negedge clk);

    // Reset with every slave valid toward this port, then a 3-beat packet from slave 1.
    tbl[0] = mk(1, 2'b11, 2'b00, 1, 1, 8'hA1, 2'b00, 0, 8'h00, 0, 0, 0, 1);
    tbl[1] = mk(1, 2'b11, 2'b00, 1, 1, 8'hA1, 2'b00, 0, 8'h00, 0, 0, 0, 1);
    tbl[2] = mk(0, 2'b11, 2'b00, 1, 1, 8'hA1, 2'b00, 0, 8'h00, 0, 0, 0, 1);
    tbl[3] = mk(0, 2'b11, 2'b00, 1, 1, 8'hA1, 2'b10, 0, 8'h00, 0, 0, 1, 1);
    tbl[4] = mk(0, 2'b11, 2'b00, 1, 1, 8'hA2, 2'b10, 1, 8'hA1, 0, 1, 1, 1);
    tbl[5] = mk(0, 2'b11, 2'b10, 1, 1, 8'hA3, 2'b10, 1, 8'hA2, 0, 1, 1, 1);
    tbl[6] = mk(0, 2'b01, 2'b00, 1, 1, 8'h00, 2'b00, 1, 8'hA3, 1, 1, 0, 1);
    tbl[7] = mk(0, 2'b01, 2'b00, 1, 1, 8'h00, 2'b00, 0, 8'h00, 0, 0, 0, 0);
    for (int i = 0; i < 8; i++) begin
      rst = tbl[i].rst; s_valid = tbl[i].valid; s_last = tbl[i].last;
      grant = tbl[i].grant; m_ready = tbl[i].mready;
      s_data[0] = 8'h55; s_data[1] = tbl[i].d1;
      s_dest[0] = DW'(IDX); s_dest[1] = DW'(IDX);
      check($sformatf("tbl%0d_s_ready", i), s_ready, tbl[i].e_ready);
      check($sformatf("tbl%0d_m_valid", i), m_valid, tbl[i].e_valid);
      check($sformatf("tbl%0d_busy", i), busy, tbl[i].e_busy);
      if (tbl[i].cd) begin
        check($sformatf("tbl%0d_m_data", i), m_data, tbl[i].e_data);
        check($sformatf("tbl%0d_m_last", i), m_last, tbl[i].e_last);
        check($sformatf("tbl%0d_m_id", i), m_id, tbl[i].e_id);
      end
      step(1'b0);
    end

    // Backpressure: only two beats fit, then the stall drains in order.
    do_reset();
    set_pkt(1, 8'hA1, 3, DW'(IDX));
    grant = 1; m_ready = 1'b0;
    repeat (6) cyc();
    check("bp_accepted", src_pos[1], 2);
    check("bp_ready_low", s_ready, 2'b00);
    m_ready = 1'b1;
    repeat (8) cyc();
    check("bp_all_accepted", src_pos[1], 3);
    check_rx("bp_rx", '{8'hA1, 8'hA2, 8'hA3});

    // Grant moves to slave 0 mid-packet: lock must hold on slave 1.
    do_reset();
    set_pkt(1, 8'hB1, 3, DW'(IDX));
    set_pkt(0, 8'hC1, 2, DW'(IDX));
    grant = 1; m_ready = 1'b1;
    cyc();
    grant = 0;
    viol = 0;
    for (int n = 0; n < 20 && src_pos[0] < 2; n++) begin
      if (src_pos[1] < 3 && s_ready[0]) viol++;
      cyc();
    end
    repeat (4) cyc();
    check("gs_no_early_ready0", viol, 0);
    check("gs_slave0_done", src_pos[0], 2);
    check_rx("gs_rx", '{8'hB1, 8'hB2, 8'hB3, 8'hC1, 8'hC2});

    // Granted slave targets another master: stay idle.
    do_reset();
    set_pkt(0, 8'hD1, 2, DW'(IDX + 1));
    grant = 0; m_ready = 1'b1;
    repeat (4) cyc();
    check("od_s_ready", s_ready, 2'b00);
    check("od_m_valid", m_valid, 1'b0);
    check("od_busy", busy, 1'b0);
    check("od_accepted", src_pos[0], 0);

    // Reset with one beat buffered mid-packet, then a clean new packet.
    do_reset();
    set_pkt(1, 8'hE1, 3, DW'(IDX));
    grant = 1; m_ready = 1'b0;
    cyc();
    cyc();
    check("rs_buffered", m_valid, 1'b1);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    check("rs_flush_valid", m_valid, 1'b0);
    check("rs_flush_busy", busy, 1'b0);
    set_pkt(1, 8'h71, 3, DW'(IDX));
    rx.delete();
    m_ready = 1'b1;
    repeat (10) cyc();
    check_rx("rs_rx", '{8'h71, 8'h72, 8'h73});

    // Randomized traffic with gaps, backpressure, grant churn and occasional reset.
    do_reset();
    gap_pct = 25;
    for (int n = 0; n < 3000; n++) begin
      for (int s = 0; s < S; s++) begin
        if (src_pos[s] >= src_len[s] || (src_dst[s] != DW'(IDX) && $urandom_range(7) == 0)) begin
          src_len[s] = $urandom_range(4, 1);
          src_pos[s] = 0;
          src_dst[s] = DW'($urandom_range(3));
          for (int i = 0; i < src_len[s]; i++) src_pkt[s][i] = W'($urandom);
        end
      end
      grant   = IW'($urandom_range(1));
      m_ready = ($urandom_range(3) != 0);
      rst     = ($urandom_range(255) == 0);
      cyc();
    end
    rst = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/master_port_stage.md
Name: master_port_stage

Overview:
- Per-master-port output stage of the stream crossbar, one instance per master index.
- Consumes the per-master grant from the arbitration unit and locks onto the granted slave for a whole packet.
- Returns s_ready only to the locked slave.
- Multiplexes that slave's beats into a 2-entry output buffer that drives the master port, and releases the lock on the accepted last beat.

Parameters:
- T_DATA_WIDTH, 8, data width per beat
- S_DATA_COUNT, 2, number of slave (source) streams
- M_DATA_COUNT, 3, number of master ports in the crossbar
- T_ID___WIDTH, $clog2(S_DATA_COUNT), width of slave id / grant
- T_DEST_WIDTH, $clog2(M_DATA_COUNT), width of dest field
- MASTER_IDX, 0, index of the master port this instance serves

Ports:
- clk_i  input  1  clock; single clock domain, all logic rising-edge
- rst_i  input  1  synchronous, active-high reset
- s_data_i  input  [T_DATA_WIDTH-1:0] x S_DATA_COUNT (unpacked)  slave data
- s_dest_i  input  [T_DEST_WIDTH-1:0] x S_DATA_COUNT (unpacked)  slave destination
- s_last_i  input  S_DATA_COUNT  slave last flags
- s_valid_i  input  S_DATA_COUNT  slave valid flags
- s_ready_o  output  S_DATA_COUNT  ready back to slaves; at most one bit high
- grant_i  input  T_ID___WIDTH  arbiter-selected slave id for MASTER_IDX
- m_data_o  output  T_DATA_WIDTH  master data
- m_last_o  output  1  master last
- m_id_o  output  T_ID___WIDTH  source slave id of current beat
- m_valid_o  output  1  master valid
- m_ready_i  input  1  master ready
- busy_o  output  1  high while locked to a slave (state BUSY)

Behaviour:
- Reset values (while rst_i high, and on the cycle after it is released):
  - m_valid_o=0, m_data_o=0, m_last_o=0, m_id_o=0, s_ready_o=0, busy_o=0.
  - State IDLE, buffer count 0, lock_id 0.
- req = s_valid_i[grant_i] && (s_dest_i[grant_i] == MASTER_IDX).
- FSM:
  - IDLE: s_ready_o=0. If req, register lock_id<=grant_i and go to BUSY next cycle. Otherwise stay.
  - BUSY: s_ready_o[lock_id] = (count < 2); all other bits 0. A beat is accepted when s_valid_i[lock_id] && s_ready_o[lock_id]. On an accepted beat with s_last_i[lock_id]=1, go to IDLE next cycle.
- grant_i is ignored while BUSY; lock_id is stable for the whole packet.
- Lock-to-first-ready latency: 1 cycle (req in cycle N, s_ready high in N+1 if buffer has space).
- Output buffer: 2-entry FIFO holding {data, last, id=lock_id}.
  - Push on accepted beat; pop when m_valid_o && m_ready_i.
  - Outputs are the head entry, registered. A beat accepted in cycle N is visible on m_valid_o in N+1 (when the buffer was empty).
  - m_valid_o = (count != 0).
  - Simultaneous push and pop: count unchanged, order preserved.
  - s_ready is computed from the current count. At count==2 with a pop in the same cycle, s_ready stays 0 that cycle and rises the next.
- Buffered beats drain after the FSM returns to IDLE. A new lock may be taken while old beats are still in the buffer; ordering is preserved.
- Slave drops valid mid-packet: stay locked in BUSY indefinitely, no timeout.
- Grant points to a slave with other dest or no valid: stay in IDLE.
- Single-beat packet: lock, accept beat with last, IDLE, so the earliest next lock is 2 cycles after the first.
- Reset asserted mid-packet: buffer discarded, FSM to IDLE, all outputs to reset values on the next edge.

Test Plan:
- Reset with s_valid_i=all ones, dest=MASTER_IDX -> all outputs 0 during reset; first s_ready_o bit rises 2 cycles after reset release.
- S=2, grant_i=1, slave1 sends 3 beats 0xA1,0xA2,0xA3(last), m_ready_i=1 -> s_ready_o=2'b10 while BUSY. m_data_o shows A1,A2,A3 on consecutive cycles starting 1 cycle after the first accept, with m_id_o=1 and m_last_o only on A3. busy_o falls after A3 is accepted.
- Same packet with m_ready_i=0 -> exactly 2 beats accepted, then s_ready_o=0. Raising m_ready_i drains A1,A2,A3 in order with no loss or duplication.
- grant_i switches 1->0 mid-packet while slave0 is valid -> lock holds on slave1 and s_ready_o[0] stays 0 until slave1's last beat is accepted.
- Slave0 dest=MASTER_IDX+1, grant_i=0 -> stays IDLE, s_ready_o=0, m_valid_o=0.
- Reset asserted after 1 of 3 beats is buffered -> m_valid_o=0 next cycle. After release, a new packet is transferred cleanly with no stale beat.
